// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type, memory arbiter FSM states and the
// saturating increment used by the arbiter starvation counter.
package cpu_types_pkg;

   localparam int WORD_W   = 32;
   localparam int STREAK_W = 4;

   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [STREAK_W-1:0] streak_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_IBUSY = 2'd1,
      ARB_DBUSY = 2'd2
   } arb_state_t;

   function automatic streak_t sat_inc(input streak_t v, input streak_t lim);
      return (v >= lim) ? lim : v + streak_t'(1);
   endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Signal bundle between the cache requesters, the shared RAM port and the arbiter.
// The arb modport is the arbiter's view; tb is the requester/RAM side.
interface memory_arbiter_if;

   logic                 iREN;
   cpu_types_pkg::word_t iaddr;
   logic                 ihit;
   cpu_types_pkg::word_t iload;
   logic                 dREN;
   logic                 dWEN;
   cpu_types_pkg::word_t daddr;
   cpu_types_pkg::word_t dstore;
   logic                 dhit;
   cpu_types_pkg::word_t dload;
   logic                 ram_REN;
   logic                 ram_WEN;
   cpu_types_pkg::word_t ram_addr;
   cpu_types_pkg::word_t ram_store;
   cpu_types_pkg::word_t ram_load;
   logic                 ram_ready;
   logic                 busy;

   modport arb (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
      output ihit, iload, dhit, dload, ram_REN, ram_WEN, ram_addr, ram_store, busy
   );

   modport tb (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
      input  ihit, iload, dhit, dload, ram_REN, ram_WEN, ram_addr, ram_store, busy
   );

endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins unless
// an instruction request has waited STARVE_LIM consecutive data grants.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIM = 4
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  iREN,
   input  word_t iaddr,
   output logic  ihit,
   output word_t iload,
   input  logic  dREN,
   input  logic  dWEN,
   input  word_t daddr,
   input  word_t dstore,
   output logic  dhit,
   output word_t dload,
   output logic  ram_REN,
   output logic  ram_WEN,
   output word_t ram_addr,
   output word_t ram_store,
   input  word_t ram_load,
   input  logic  ram_ready,
   output logic  busy
);

   localparam streak_t LIM = streak_t'(STARVE_LIM);

   arb_state_t state_q;
   streak_t    streak_q, streak_d;
   logic       write_q;
   logic       ren_q, wen_q;
   word_t      addr_q, store_q;
   logic       dreq, d_grant;

   assign dreq     = dREN | dWEN;
   assign d_grant  = dreq && !(iREN && (streak_q == LIM));
   // Streak only grows while instruction fetch is actually being held off.
   assign streak_d = iREN ? sat_inc(streak_q, LIM) : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ARB_IDLE;
         streak_q <= '0;
         write_q  <= 1'b0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         addr_q   <= '0;
         store_q  <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (d_grant) begin
                  state_q  <= ARB_DBUSY;
                  streak_q <= streak_d;
                  write_q  <= dWEN;
                  wen_q    <= dWEN;
                  ren_q    <= !dWEN;
                  addr_q   <= daddr;
                  store_q  <= dstore;
               end else if (iREN) begin
                  state_q  <= ARB_IBUSY;
                  streak_q <= '0;
                  write_q  <= 1'b0;
                  ren_q    <= 1'b1;
                  wen_q    <= 1'b0;
                  addr_q   <= iaddr;
                  store_q  <= '0;
               end
            end
            default: begin
               if (ram_ready) begin
                  state_q <= ARB_IDLE;
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
                  addr_q  <= '0;
                  store_q <= '0;
               end
            end
         endcase
      end
   end

   assign busy      = (state_q != ARB_IDLE);
   assign ihit      = (state_q == ARB_IBUSY) && ram_ready;
   assign dhit      = (state_q == ARB_DBUSY) && ram_ready;
   assign iload     = ihit ? ram_load : '0;
   assign dload     = (dhit && !write_q) ? ram_load : '0;
   assign ram_REN   = ren_q;
   assign ram_WEN   = wen_q;
   assign ram_addr  = addr_q;
   assign ram_store = store_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance with the default starvation
// limit and one with STARVE_LIM=0 (instruction priority).
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   memory_arbiter_if a ();
   memory_arbiter_if b ();

   always #5 CLK = ~CLK;

   memory_arbiter #(.STARVE_LIM(4)) dut_a (
      .CLK(CLK), .RST(RST),
      .iREN(a.iREN), .iaddr(a.iaddr), .ihit(a.ihit), .iload(a.iload),
      .dREN(a.dREN), .dWEN(a.dWEN), .daddr(a.daddr), .dstore(a.dstore),
      .dhit(a.dhit), .dload(a.dload),
      .ram_REN(a.ram_REN), .ram_WEN(a.ram_WEN), .ram_addr(a.ram_addr),
      .ram_store(a.ram_store), .ram_load(a.ram_load), .ram_ready(a.ram_ready),
      .busy(a.busy)
   );

   memory_arbiter #(.STARVE_LIM(0)) dut_b (
      .CLK(CLK), .RST(RST),
      .iREN(b.iREN), .iaddr(b.iaddr), .ihit(b.ihit), .iload(b.iload),
      .dREN(b.dREN), .dWEN(b.dWEN), .daddr(b.daddr), .dstore(b.dstore),
      .dhit(b.dhit), .dload(b.dload),
      .ram_REN(b.ram_REN), .ram_WEN(b.ram_WEN), .ram_addr(b.ram_addr),
      .ram_store(b.ram_store), .ram_load(b.ram_load), .ram_ready(b.ram_ready),
      .busy(b.busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_edge();
      @(posedge CLK);
      #1;
   endtask

   // One read transaction on instance a: grant edge, ready pulse, completion edge.
   task automatic txn(input bit is_i, input word_t exp_addr, input word_t rload);
      wait_edge();
      chk(is_i ? "i_grant_ren" : "d_grant_ren", {31'd0, a.ram_REN}, 32'd1);
      chk(is_i ? "i_grant_addr" : "d_grant_addr", a.ram_addr, exp_addr);
      a.ram_ready = 1'b1;
      a.ram_load  = rload;
      #1;
      chk("txn_ihit", {31'd0, a.ihit}, {31'd0, is_i});
      chk("txn_dhit", {31'd0, a.dhit}, {31'd0, !is_i});
      if (is_i) begin
         chk("txn_iload", a.iload, rload);
         a.iaddr = a.iaddr + 32'd4;
      end else begin
         chk("txn_dload", a.dload, rload);
         a.daddr = a.daddr + 32'd4;
      end
      wait_edge();
      a.ram_ready = 1'b0;
      #1;
      chk("txn_idle", {31'd0, a.busy}, 32'd0);
   endtask

   initial begin
      bit kinds [10];
      int ic, dc;
      kinds = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

      // Reset with random requester/RAM activity
      a.iREN = 1'b1; a.iaddr = $urandom; a.dREN = 1'b1; a.dWEN = 1'b1;
      a.daddr = $urandom; a.dstore = $urandom; a.ram_load = $urandom; a.ram_ready = 1'b1;
      b.iREN = 1'b0; b.iaddr = '0; b.dREN = 1'b0; b.dWEN = 1'b0;
      b.daddr = '0; b.dstore = '0; b.ram_load = '0; b.ram_ready = 1'b0;
      wait_edge();
      wait_edge();
      chk("rst_ren",   {31'd0, a.ram_REN}, 32'd0);
      chk("rst_wen",   {31'd0, a.ram_WEN}, 32'd0);
      chk("rst_addr",  a.ram_addr, 32'd0);
      chk("rst_store", a.ram_store, 32'd0);
      chk("rst_hits",  {30'd0, a.ihit, a.dhit}, 32'd0);
      chk("rst_loads", a.iload | a.dload, 32'd0);
      chk("rst_busy",  {31'd0, a.busy}, 32'd0);
      a.iREN = 1'b0; a.dREN = 1'b0; a.dWEN = 1'b0; a.ram_ready = 1'b0;
      a.iaddr = '0; a.daddr = '0; a.dstore = '0; a.ram_load = '0;
      RST = 1'b0;

      // Instruction fetch, RAM ready two cycles after the strobe
      wait_edge();
      a.iREN = 1'b1; a.iaddr = 32'h0000_0040;
      wait_edge();
      chk("if_ren",  {31'd0, a.ram_REN}, 32'd1);
      chk("if_addr", a.ram_addr, 32'h40);
      chk("if_busy", {31'd0, a.busy}, 32'd1);
      chk("if_nohit_early", {31'd0, a.ihit}, 32'd0);
      wait_edge();
      wait_edge();
      a.ram_ready = 1'b1; a.ram_load = 32'h2401_0005;
      #1;
      chk("if_ihit",  {31'd0, a.ihit}, 32'd1);
      chk("if_iload", a.iload, 32'h2401_0005);
      a.iREN = 1'b0;
      wait_edge();
      a.ram_ready = 1'b0;
      #1;
      chk("if_busy_low", {31'd0, a.busy}, 32'd0);
      chk("if_single_hit", {31'd0, a.ihit}, 32'd0);

      // dREN and dWEN together act as a write
      a.dREN = 1'b1; a.dWEN = 1'b1; a.daddr = 32'h100; a.dstore = 32'hDEAD_BEEF;
      wait_edge();
      chk("wr_wen",   {31'd0, a.ram_WEN}, 32'd1);
      chk("wr_ren",   {31'd0, a.ram_REN}, 32'd0);
      chk("wr_addr",  a.ram_addr, 32'h100);
      chk("wr_store", a.ram_store, 32'hDEAD_BEEF);
      a.ram_ready = 1'b1; a.ram_load = 32'h1234_5678;
      #1;
      chk("wr_dhit",  {31'd0, a.dhit}, 32'd1);
      chk("wr_dload", a.dload, 32'd0);
      a.dREN = 1'b0; a.dWEN = 1'b0;
      wait_edge();
      a.ram_ready = 1'b0;
      #1;
      chk("wr_idle_strobe", {31'd0, a.ram_WEN}, 32'd0);

      // ram_ready in idle is ignored
      a.ram_ready = 1'b1; a.ram_load = 32'hFFFF_FFFF;
      #1;
      chk("idle_rdy_hits", {30'd0, a.ihit, a.dhit}, 32'd0);
      wait_edge();
      chk("idle_rdy_busy", {31'd0, a.busy}, 32'd0);
      chk("idle_rdy_hits2", {30'd0, a.ihit, a.dhit}, 32'd0);
      a.ram_ready = 1'b0;

      // Starvation limit 4: four data grants, one fetch, repeat
      a.iREN = 1'b1; a.iaddr = 32'h80; a.dREN = 1'b1; a.daddr = 32'h200;
      ic = 0; dc = 0;
      for (int k = 0; k < 10; k++) begin
         if (kinds[k]) begin
            txn(1'b1, 32'h80 + 32'(4 * ic), 32'hA000_0000 + 32'(k));
            ic++;
         end else begin
            txn(1'b0, 32'h200 + 32'(4 * dc), 32'hB000_0000 + 32'(k));
            dc++;
         end
      end

      // Build streak to 4 then reset mid-write; streak must restart at 0
      txn(1'b0, 32'h220, 32'hC000_0001);
      txn(1'b0, 32'h224, 32'hC000_0002);
      txn(1'b0, 32'h228, 32'hC000_0003);
      a.dREN = 1'b0; a.dWEN = 1'b1; a.dstore = 32'hCAFE_F00D;
      wait_edge();
      chk("rstmid_wen_before", {31'd0, a.ram_WEN}, 32'd1);
      chk("rstmid_addr", a.ram_addr, 32'h22C);
      a.ram_ready = 1'b1;
      #1;
      RST = 1'b1;
      #1;
      chk("rstmid_wen_drop", {31'd0, a.ram_WEN}, 32'd0);
      chk("rstmid_dhit", {31'd0, a.dhit}, 32'd0);
      chk("rstmid_busy", {31'd0, a.busy}, 32'd0);
      a.ram_ready = 1'b0;
      RST = 1'b0;
      a.dWEN = 1'b0; a.dREN = 1'b1; a.daddr = 32'h300;
      txn(1'b0, 32'h300, 32'hD000_0000);
      a.iREN = 1'b0; a.dREN = 1'b0;

      // STARVE_LIM=0: simultaneous requests favour instruction fetch
      b.iREN = 1'b1; b.dREN = 1'b1; b.iaddr = 32'h40; b.daddr = 32'h500;
      wait_edge();
      chk("p0_first_ren", {31'd0, b.ram_REN}, 32'd1);
      chk("p0_first_addr", b.ram_addr, 32'h40);
      b.ram_ready = 1'b1; b.ram_load = 32'h0000_0011;
      #1;
      chk("p0_ihit", {30'd0, b.ihit, b.dhit}, 32'd2);
      b.iREN = 1'b0;
      wait_edge();
      b.ram_ready = 1'b0;
      wait_edge();
      chk("p0_second_addr", b.ram_addr, 32'h500);
      b.ram_ready = 1'b1; b.ram_load = 32'h0000_0022;
      #1;
      chk("p0_dhit", {30'd0, b.ihit, b.dhit}, 32'd1);
      chk("p0_dload", b.dload, 32'h22);
      b.dREN = 1'b0;
      wait_edge();
      b.ram_ready = 1'b0;
      #1;
      chk("p0_idle", {31'd0, b.busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Sequential arbiter sharing the single RAM port between the instruction-fetch requester (icache side) and the data requester (dcache side). Sits between the caches and the RAM, downstream of the request unit's imemREN/dmemREN/dmemWEN strobes, and returns ihit/dhit to it. Data requests get priority, bounded by a starvation limit so instruction fetch always makes progress. One RAM transaction is outstanding at a time.

Parameters:
STARVE_LIM, 4, maximum consecutive data grants while an instruction request waits; legal range 0..15; 0 gives instruction priority.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
iREN  input  1  instruction read request, held until ihit
iaddr  input  32  instruction word address (word_t)
ihit  output  1  one-cycle instruction completion pulse
iload  output  32  fetched instruction, valid only while ihit=1
dREN  input  1  data read request, held until dhit
dWEN  input  1  data write request, held until dhit
daddr  input  32  data address
dstore  input  32  write data
dhit  output  1  one-cycle data completion pulse
dload  output  32  read data, valid only while dhit=1
ram_REN  output  1  RAM read strobe
ram_WEN  output  1  RAM write strobe
ram_addr  output  32  RAM address
ram_store  output  32  RAM write data
ram_load  input  32  RAM read data
ram_ready  input  1  RAM completion, one cycle, valid only while a strobe is high
busy  output  1  a transaction is in progress

Behaviour:
- Reset (async, immediate): state ARB_IDLE, streak counter 0, latched addr/data/direction 0. All outputs 0.
- States: ARB_IDLE, ARB_IBUSY, ARB_DBUSY. busy = (state != ARB_IDLE).
- In ARB_IDLE, with dreq = dREN|dWEN, on the clock edge:
  - dreq && !(iREN && streak==STARVE_LIM): go to ARB_DBUSY. Latch daddr, dstore, write=dWEN. streak <= iREN ? streak+1 : 0, saturating at STARVE_LIM.
  - else if iREN: go to ARB_IBUSY. Latch iaddr. streak <= 0.
  - else: stay in ARB_IDLE. streak holds.
- dREN and dWEN both high: treated as a write.
- ARB_IBUSY: ram_REN=1, ram_addr=latched addr.
- ARB_DBUSY: ram_WEN=write, ram_REN=!write, ram_addr and ram_store from latches.
- Strobes, ram_addr and ram_store are driven from registers only. They are 0 in ARB_IDLE.
- Completion: ihit = (state==ARB_IBUSY) && ram_ready. dhit = (state==ARB_DBUSY) && ram_ready. Both are combinational from ram_ready.
- iload = ihit ? ram_load : 0. dload = (dhit && !write) ? ram_load : 0.
- On the completion edge the state returns to ARB_IDLE. The next grant is decided in ARB_IDLE. Minimum spacing between grants is 2 cycles.
- Latency: request visible in cycle N gives a strobe in N+1; hit arrives in the first cycle ram_ready=1, earliest N+1.
- Requester inputs are ignored while busy; the latched values are used.
- If a requester drops its request mid-transaction, the transaction still completes and the hit still pulses.
- ram_ready while in ARB_IDLE is ignored: no hit and no state change.
- A transaction never aborts. ram_ready is awaited indefinitely, with no timeout.
- RST mid-transaction: strobes and hits drop asynchronously. The RAM must treat a dropped strobe as a cancel.

Decomposition:
- Add arb_state_t (ARB_IDLE, ARB_IBUSY, ARB_DBUSY) to cpu_types_pkg. Use word_t for all 32-bit signals.
- Add memory_arbiter_if.vh with modports arb and tb.
- No sub-module: the FSM plus the saturating streak counter stays in a single module.

Test Plan:
- RST=1 with random inputs -> all outputs 0, busy=0. Also assert RST mid-ARB_DBUSY with no clock edge -> ram_WEN falls to 0 immediately. After release, the first grant starts from ARB_IDLE with streak=0.
- iREN=1, iaddr=0x0000_0040. RAM asserts ram_ready 2 cycles after ram_REN rises, ram_load=0x2401_0005 -> ram_addr=0x40, a single ihit pulse, iload=0x2401_0005, busy low the cycle after.
- dWEN=1 and dREN=1, daddr=0x100, dstore=0xDEAD_BEEF -> ram_WEN=1, ram_REN=0, ram_store=0xDEADBEEF, dhit pulse, dload=0.
- STARVE_LIM=4, iREN held, dREN held with new daddr after each dhit -> exactly 4 dhits, then one ihit, then data grants resume with streak restarted.
- STARVE_LIM=0, iREN and dREN raised in the same cycle -> instruction granted first, data second.
- ram_ready pulsed while in ARB_IDLE with no requests -> ihit=dhit=0, state stays ARB_IDLE.
